alu_op_sequencer: RTL and testbench

- Registered front end that sits directly upstream of the 6-bit combinational ALU and consumes its result.
- Accepts one operation at a time over a valid/ready handshake: operand A, operand B, and the 3-bit f/x/n select.
- Holds the operands stable on the ALU inputs, waits a fixed settle time, captures the ALU output, and presents it downstream over a second valid/ready handshake.
- Supports chaining: the previous result can replace operand A, which enables multi-step accumulation from board switches.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_settle_counter.sv | 28 ++
 rtl/alu_op_sequencer.sv | 110 +++++++++++
 tb/tb_alu_op_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU front end: datapath width, {f,x,n} select codes
// and the sequencer state type.
`timescale 1ns/1ps
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 6;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_N    = 3'b001;
  localparam logic [2:0] OP_X    = 3'b010;
  localparam logic [2:0] OP_XN   = 3'b011;
  localparam logic [2:0] OP_F    = 3'b100;
  localparam logic [2:0] OP_FN   = 3'b101;
  localparam logic [2:0] OP_FX   = 3'b110;
  localparam logic [2:0] OP_FXN  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/alu_settle_counter.sv
// Loadable down-counter that times how long the ALU inputs are held before capture.
`timescale 1ns/1ps
module alu_settle_counter #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered front end for the combinational ALU: accepts one op, holds the ALU
// inputs for a settle time, captures the result and hands it downstream.
`timescale 1ns/1ps
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH         = ALU_WIDTH,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned COUNT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  input  logic [2:0]             in_op,
  input  logic                   in_chain,
  output logic [WIDTH-1:0]       alu_input1,
  output logic [WIDTH-1:0]       alu_input2,
  output logic                   alu_f,
  output logic                   alu_x,
  output logic                   alu_n,
  input  logic [WIDTH-1:0]       alu_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_result,
  output logic [2:0]             out_op,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] op_count
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [WIDTH-1:0] last_result;
  logic             rst_meta;
  logic             rst_sync;
  logic             cnt_zero;
  logic             accept;

  // Assertion is immediate; release is retimed to clk through two flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_sync <= rst_meta;
    end
  end

  assign in_ready = rst_sync && (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign accept   = in_valid && in_ready;

  alu_settle_counter #(.CW(4)) u_settle (
    .clk        (clk),
    .reset_n    (rst_sync),
    .load       (accept),
    .load_value (SETTLE_LOAD),
    .dec        (state == ST_SETTLE),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      state       <= ST_IDLE;
      alu_input1  <= '0;
      alu_input2  <= '0;
      alu_f       <= 1'b0;
      alu_x       <= 1'b0;
      alu_n       <= 1'b0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_op      <= '0;
      op_count    <= '0;
      last_result <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            alu_input1 <= in_chain ? last_result : in_a;
            alu_input2 <= in_b;
            {alu_f, alu_x, alu_n} <= in_op;
            state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_zero) begin
            out_result  <= alu_result;
            last_result <= alu_result;
            out_op      <= {alu_f, alu_x, alu_n};
            out_valid   <= 1'b1;
            state       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            op_count  <= op_count + COUNT_WIDTH'(1);
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench: two sequencer instances (settle 1 / count 8, settle 4 / count 2)
// driven by directed and random ops, checked against a plain arithmetic model.
`timescale 1ns/1ps
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] in_a = '0, in_b = '0;
  logic [2:0] in_op = '0;
  logic       in_chain = 1'b0;

  // instance 1: SETTLE_CYCLES=1, COUNT_WIDTH=8
  logic       v1 = 1'b0, or1 = 1'b0;
  logic       ir1, ov1, f1, x1, n1, busy1;
  logic [5:0] ai1, bi1, res1, orz1;
  logic [2:0] oop1;
  logic [7:0] cnt1;
  assign res1 = ai1 + bi1;

  // instance 4: SETTLE_CYCLES=4, COUNT_WIDTH=2
  logic       v4 = 1'b0, or4 = 1'b0;
  logic       ir4, ov4, f4, x4, n4, busy4;
  logic [5:0] ai4, bi4, res4, orz4, sum4;
  logic [2:0] oop4;
  logic [1:0] cnt4;
  logic       glitch = 1'b0;
  logic [5:0] junk = '0;
  assign sum4 = ai4 + bi4;
  assign res4 = glitch ? junk : sum4;

  alu_op_sequencer #(.WIDTH(6), .SETTLE_CYCLES(1), .COUNT_WIDTH(8)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(v1), .in_ready(ir1),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_chain(in_chain),
    .alu_input1(ai1), .alu_input2(bi1), .alu_f(f1), .alu_x(x1), .alu_n(n1),
    .alu_result(res1), .out_valid(ov1), .out_ready(or1), .out_result(orz1),
    .out_op(oop1), .busy(busy1), .op_count(cnt1)
  );

  alu_op_sequencer #(.WIDTH(6), .SETTLE_CYCLES(4), .COUNT_WIDTH(2)) dut4 (
    .clk(clk), .reset_n(reset_n), .in_valid(v4), .in_ready(ir4),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_chain(in_chain),
    .alu_input1(ai4), .alu_input2(bi4), .alu_f(f4), .alu_x(x4), .alu_n(n4),
    .alu_result(res4), .out_valid(ov4), .out_ready(or4), .out_result(orz4),
    .out_op(oop4), .busy(busy4), .op_count(cnt4)
  );

  int unsigned n_chk = 0, n_pass = 0;
  int unsigned m_last1 = 0, m_cnt1 = 0, m_last4 = 0, m_cnt4 = 0;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input bit which4, input string tag);
    int unsigned w = 0;
    while (!(which4 ? ir4 : ir1) && w < 20) begin
      tick();
      w++;
    end
    chk(tag, int'(which4 ? ir4 : ir1), 1);
  endtask

  task automatic run1(input int unsigned a, input int unsigned b, input int unsigned op,
                      input bit ch, input int unsigned hold);
    int unsigned e_in1, e_res;
    e_in1 = ch ? m_last1 : a;
    e_res = (e_in1 + b) % 64;
    in_a = 6'(a); in_b = 6'(b); in_op = 3'(op); in_chain = ch;
    or1 = (hold == 0);
    v1 = 1'b1;
    wait_ready(1'b0, "ready1");
    tick();
    v1 = 1'b0;
    chk("alu_input1", ai1, e_in1);
    chk("alu_input2", bi1, b);
    chk("alu_op", {f1, x1, n1}, op);
    chk("settle_no_valid", ov1, 0);
    tick();
    chk("latency1", ov1, 1);
    chk("result1", orz1, e_res);
    chk("out_op1", oop1, op);
    chk("ready_low_hold", ir1, 0);
    if (hold > 0) begin
      in_a = ~6'(a); in_chain = 1'b0; v1 = 1'b1;
      for (int i = 0; i < int'(hold); i++) begin
        tick();
        chk("bp_valid", ov1, 1);
        chk("bp_result", orz1, e_res);
        chk("bp_ready", ir1, 0);
      end
      v1 = 1'b0;
      chk("ignored_req", ai1, e_in1);
      or1 = 1'b1;
    end
    tick();
    m_last1 = e_res;
    m_cnt1 = (m_cnt1 + 1) % 256;
    chk("hs_valid_drop", ov1, 0);
    chk("op_count1", cnt1, m_cnt1);
    chk("ready_after_hs", ir1, 1);
  endtask

  task automatic run4(input int unsigned a, input int unsigned b, input int unsigned op,
                      input bit ch);
    int unsigned e_in1, e_res;
    e_in1 = ch ? m_last4 : a;
    e_res = (e_in1 + b) % 64;
    in_a = 6'(a); in_b = 6'(b); in_op = 3'(op); in_chain = ch;
    or4 = 1'b1;
    v4 = 1'b1;
    wait_ready(1'b1, "ready4");
    tick();
    v4 = 1'b0;
    junk = 6'(e_res) ^ 6'($urandom_range(1, 63));
    glitch = 1'b1;
    chk("alu_input1_4", ai4, e_in1);
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk("settle4_no_valid", ov4, 0);
      // different junk is presented across edge 3, real sum only for edge 4
      if (e == 2) junk = 6'(e_res) ^ 6'($urandom_range(1, 63));
      if (e == 3) glitch = 1'b0;
    end
    tick();
    chk("latency4", ov4, 1);
    chk("result4", orz4, e_res);
    chk("out_op4", oop4, op);
    tick();
    m_last4 = e_res;
    m_cnt4 = (m_cnt4 + 1) % 4;
    chk("hs4_valid_drop", ov4, 0);
    chk("op_count4", cnt4, m_cnt4);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_in_ready", ir1, 0);
    chk("rst_out_valid", ov1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_op_count", cnt1, 0);
    chk("rst_alu_input1", ai1, 0);
    chk("rst_out_result", orz1, 0);
    reset_n = 1'b1;
    wait_ready(1'b0, "release_ready1");

    run1(5, 9, 3'b000, 1'b0, 0);
    run1(5, 9, 3'b000, 1'b0, 10);
    run1(60, 3, 3'b101, 1'b0, 0);
    run1(0, 2, 3'b010, 1'b1, 1);
    run1(0, 0, 3'b111, 1'b1, 0);

    for (int i = 0; i < 20; i++)
      run1($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 7),
           1'($urandom_range(0, 1)), $urandom_range(0, 3));

    // reset asserted while dut1 is in SETTLE
    in_a = 6'd17; in_b = 6'd20; in_chain = 1'b0; or1 = 1'b1; v1 = 1'b1;
    wait_ready(1'b0, "ready_pre_rst");
    tick();
    v1 = 1'b0;
    chk("pre_rst_busy", busy1, 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", ov1, 0);
    chk("midrst_busy", busy1, 0);
    chk("midrst_op_count", cnt1, 0);
    chk("midrst_in_ready", ir1, 0);
    m_last1 = 0; m_cnt1 = 0; m_last4 = 0; m_cnt4 = 0;
    repeat (2) tick();
    chk("midrst_no_pulse", ov1, 0);
    reset_n = 1'b1;
    wait_ready(1'b0, "release_ready1b");
    run1(33, 4, 3'b001, 1'b1, 0);

    run4(10, 7, 3'b100, 1'b0);
    for (int i = 0; i < 4; i++)
      run4($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 7),
           1'($urandom_range(0, 1)));
    chk("count_wrap", cnt4, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
